// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard detection and forwarding control for the 5-stage MIPS pipeline.
//
// Tracks {destination, remaining latency Tnew} for the instructions in E, M and W, and
// compares them with the read latency Tuse of the instruction in D. It produces the stall
// request and the forwarding mux selects, and it runs the mult/div busy counter that holds
// off HI/LO accesses while a multicycle operation is in flight.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   d_rs_addr, d_rt_addr    source registers of the D-stage instruction
//   d_tuse_rs, d_tuse_rt    cycles until D needs rs/rt (all-ones = operand not read)
//   d_wr_addr, d_tnew       destination of the D instruction and its Tnew on entry to E
//   d_md_use                D instruction touches the mult/div unit or HI/LO
//   e_md_start, e_md_div    E instruction starts a mult (div=0) or div (div=1)
//   stall                   freeze PC and F/D, bubble into E
//   fwd_rs_d, fwd_rt_d      D operand select: 0 regfile, 1 E, 2 M, 3 W
//   fwd_rs_e, fwd_rt_e      E operand select: 0 pipe reg, 2 M, 3 W
//   fwd_rt_m                M store data takes the W result
//   md_busy                 mult/div counter non-zero
module hazard_ctrl #(
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned TNEW_W  = 2,
    parameter int unsigned MUL_LAT = 5,
    parameter int unsigned DIV_LAT = 10,
    parameter bit          FWD_EN  = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] d_rs_addr,
    input  logic [REG_AW-1:0] d_rt_addr,
    input  logic [TNEW_W-1:0] d_tuse_rs,
    input  logic [TNEW_W-1:0] d_tuse_rt,
    input  logic [REG_AW-1:0] d_wr_addr,
    input  logic [TNEW_W-1:0] d_tnew,
    input  logic              d_md_use,
    input  logic              e_md_start,
    input  logic              e_md_div,
    output logic              stall,
    output logic [1:0]        fwd_rs_d,
    output logic [1:0]        fwd_rt_d,
    output logic [1:0]        fwd_rs_e,
    output logic [1:0]        fwd_rt_e,
    output logic              fwd_rt_m,
    output logic              md_busy
);

    localparam int unsigned MAX_LAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
    localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);
    localparam logic [TNEW_W-1:0] TUSE_NONE = '1;

    // Producer slots
    logic [REG_AW-1:0] e_addr_q, m_addr_q, w_addr_q;
    logic [TNEW_W-1:0] e_tnew_q, m_tnew_q, w_tnew_q;
    // Source registers of the instructions now in E and M
    logic [REG_AW-1:0] e_rs_q, e_rt_q, m_rt_q;
    logic [CNT_W-1:0]  md_cnt_q, md_cnt_d;

    logic rs_rd, rt_rd;
    logic rs_e, rs_m, rs_w, rt_e, rt_m, rt_w;
    logic data_stall, md_stall;

    function automatic logic hit(input logic [REG_AW-1:0] src, input logic [REG_AW-1:0] dst);
        return (src != '0) && (src == dst);
    endfunction

    function automatic logic [TNEW_W-1:0] sat_dec(input logic [TNEW_W-1:0] t);
        return (t == '0) ? t : t - TNEW_W'(1);
    endfunction

    // Nearest-first choice among stages whose result is ready.
    function automatic logic [1:0] pick(input logic e_ok, input logic m_ok, input logic w_ok);
        if (e_ok)      return 2'd1;
        else if (m_ok) return 2'd2;
        else if (w_ok) return 2'd3;
        else           return 2'd0;
    endfunction

    assign md_busy = (md_cnt_q != '0);

    always_comb begin
        stall      = 1'b0;
        fwd_rs_d   = 2'd0;
        fwd_rt_d   = 2'd0;
        fwd_rs_e   = 2'd0;
        fwd_rt_e   = 2'd0;
        fwd_rt_m   = 1'b0;
        data_stall = 1'b0;

        rs_rd = (d_tuse_rs != TUSE_NONE);
        rt_rd = (d_tuse_rt != TUSE_NONE);
        rs_e  = rs_rd && hit(d_rs_addr, e_addr_q);
        rs_m  = rs_rd && hit(d_rs_addr, m_addr_q);
        rs_w  = rs_rd && hit(d_rs_addr, w_addr_q);
        rt_e  = rt_rd && hit(d_rt_addr, e_addr_q);
        rt_m  = rt_rd && hit(d_rt_addr, m_addr_q);
        rt_w  = rt_rd && hit(d_rt_addr, w_addr_q);

        if (FWD_EN) begin
            // W always has Tnew 0, so only E and M can make D wait.
            data_stall = (rs_e && (d_tuse_rs < e_tnew_q)) || (rs_m && (d_tuse_rs < m_tnew_q)) ||
                         (rt_e && (d_tuse_rt < e_tnew_q)) || (rt_m && (d_tuse_rt < m_tnew_q));
            fwd_rs_d = pick(rs_e && (e_tnew_q == '0), rs_m && (m_tnew_q == '0),
                            rs_w && (w_tnew_q == '0));
            fwd_rt_d = pick(rt_e && (e_tnew_q == '0), rt_m && (m_tnew_q == '0),
                            rt_w && (w_tnew_q == '0));
            fwd_rs_e = pick(1'b0, hit(e_rs_q, m_addr_q) && (m_tnew_q == '0),
                            hit(e_rs_q, w_addr_q) && (w_tnew_q == '0));
            fwd_rt_e = pick(1'b0, hit(e_rt_q, m_addr_q) && (m_tnew_q == '0),
                            hit(e_rt_q, w_addr_q) && (w_tnew_q == '0));
            fwd_rt_m = hit(m_rt_q, w_addr_q);
        end else begin
            // The regfile does not bypass its own write, so a producer sitting in W
            // must also be waited out when nothing is forwarded.
            data_stall = rs_e || rs_m || rs_w || rt_e || rt_m || rt_w;
        end

        md_stall = d_md_use && (md_busy || e_md_start);
        stall    = data_stall || md_stall;
    end

    always_comb begin
        md_cnt_d = md_cnt_q;
        if (e_md_start) begin
            md_cnt_d = e_md_div ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
        end else if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_addr_q <= '0;
            e_tnew_q <= '0;
            m_addr_q <= '0;
            m_tnew_q <= '0;
            w_addr_q <= '0;
            w_tnew_q <= '0;
            e_rs_q   <= '0;
            e_rt_q   <= '0;
            m_rt_q   <= '0;
            md_cnt_q <= '0;
        end else begin
            e_addr_q <= stall ? '0 : d_wr_addr;
            e_tnew_q <= stall ? '0 : d_tnew;
            e_rs_q   <= stall ? '0 : d_rs_addr;
            e_rt_q   <= stall ? '0 : d_rt_addr;
            m_addr_q <= e_addr_q;
            m_tnew_q <= sat_dec(e_tnew_q);
            m_rt_q   <= e_rt_q;
            w_addr_q <= m_addr_q;
            w_tnew_q <= sat_dec(m_tnew_q);
            md_cnt_q <= md_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: table-driven vectors, directed multicycle sequences and random stimulus
// against a queue-of-instructions reference model. Two DUTs share inputs: forwarding on
// (dut) and stall-only (nf).
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] d_rs_addr, d_rt_addr, d_wr_addr;
    logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
    logic       d_md_use, e_md_start, e_md_div;

    logic       stall, fwd_rt_m, md_busy;
    logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;
    logic       nf_stall, nf_fwd_rt_m, nf_md_busy;
    logic [1:0] nf_fwd_rs_d, nf_fwd_rt_d, nf_fwd_rs_e, nf_fwd_rt_e;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.FWD_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .d_rs_addr(d_rs_addr), .d_rt_addr(d_rt_addr),
        .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
        .d_wr_addr(d_wr_addr), .d_tnew(d_tnew), .d_md_use(d_md_use),
        .e_md_start(e_md_start), .e_md_div(e_md_div),
        .stall(stall), .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d),
        .fwd_rs_e(fwd_rs_e), .fwd_rt_e(fwd_rt_e), .fwd_rt_m(fwd_rt_m), .md_busy(md_busy)
    );

    hazard_ctrl #(.FWD_EN(1'b0)) nf (
        .clk(clk), .rst_n(rst_n),
        .d_rs_addr(d_rs_addr), .d_rt_addr(d_rt_addr),
        .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
        .d_wr_addr(d_wr_addr), .d_tnew(d_tnew), .d_md_use(d_md_use),
        .e_md_start(e_md_start), .e_md_div(e_md_div),
        .stall(nf_stall), .fwd_rs_d(nf_fwd_rs_d), .fwd_rt_d(nf_fwd_rt_d),
        .fwd_rs_e(nf_fwd_rs_e), .fwd_rt_e(nf_fwd_rt_e), .fwd_rt_m(nf_fwd_rt_m),
        .md_busy(nf_md_busy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int wr;
        int tnew0;
        int rs;
        int rt;
    } ent_t;

    ent_t pipe [2][3];   // [config: 0 fwd, 1 stall-only][0 E, 1 M, 2 W]
    int   cyc, md_start, md_lat;

    function automatic int rem(input ent_t e, input int k);
        return (e.tnew0 > k) ? e.tnew0 - k : 0;
    endfunction

    function automatic bit m_busy();
        return (md_lat > 0) && (cyc > md_start) && (cyc <= md_start + md_lat);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++)
            for (int k = 0; k < 3; k++) pipe[c][k] = '{0, 0, 0, 0};
        cyc = 0; md_start = 0; md_lat = 0;
    endtask

    task automatic model_eval(input int c, output int st, output int rsd, output int rtd,
                              output int rse, output int rte, output int rtm);
        int src[2], tu[2], fd[2], fe[2], a;
        src[0] = int'(d_rs_addr); src[1] = int'(d_rt_addr);
        tu[0]  = int'(d_tuse_rs); tu[1]  = int'(d_tuse_rt);
        st = 0;
        for (int s = 0; s < 2; s++) begin
            fd[s] = 0;
            for (int k = 0; k < 3; k++) begin
                if (tu[s] != 3 && src[s] != 0 && src[s] == pipe[c][k].wr) begin
                    if (c == 1 || (k < 2 && tu[s] < rem(pipe[c][k], k))) st = 1;
                    if (fd[s] == 0 && rem(pipe[c][k], k) == 0) fd[s] = k + 1;
                end
            end
            a = (s == 0) ? pipe[c][0].rs : pipe[c][0].rt;
            fe[s] = 0;
            for (int k = 1; k < 3; k++)
                if (fe[s] == 0 && a != 0 && a == pipe[c][k].wr && rem(pipe[c][k], k) == 0)
                    fe[s] = k + 1;
        end
        if (d_md_use && (m_busy() || e_md_start)) st = 1;
        rtm = (pipe[c][1].rt != 0 && pipe[c][1].rt == pipe[c][2].wr) ? 1 : 0;
        rsd = fd[0]; rtd = fd[1]; rse = fe[0]; rte = fe[1];
        if (c == 1) begin
            rsd = 0; rtd = 0; rse = 0; rte = 0; rtm = 0;
        end
    endtask

    task automatic model_advance(input int st0, input int st1);
        for (int c = 0; c < 2; c++) begin
            pipe[c][2] = pipe[c][1];
            pipe[c][1] = pipe[c][0];
            if ((c == 0 ? st0 : st1) != 0) pipe[c][0] = '{0, 0, 0, 0};
            else pipe[c][0] = '{int'(d_wr_addr), int'(d_tnew), int'(d_rs_addr), int'(d_rt_addr)};
        end
        if (e_md_start) begin
            md_start = cyc;
            md_lat   = e_md_div ? 10 : 5;
        end
        cyc++;
    endtask

    // ---------------- helpers ----------------
    task automatic set_d(input int rs, input int rt, input int tur, input int tut,
                         input int wr, input int tn);
        d_rs_addr = 5'(rs); d_rt_addr = 5'(rt);
        d_tuse_rs = 2'(tur); d_tuse_rt = 2'(tut);
        d_wr_addr = 5'(wr); d_tnew = 2'(tn);
    endtask

    task automatic set_nop();
        set_d(0, 0, 3, 3, 0, 0);
        d_md_use = 1'b0; e_md_start = 1'b0; e_md_div = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        set_nop();
        #1;
        chk("reset_stall", stall, 0);
        chk("reset_fwd", {fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m}, 0);
        chk("reset_busy", md_busy, 0);
        chk("reset_nf_stall", nf_stall, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic md_seq(input bit div, input int lat, input string nm);
        int  nb, ns;
        bit  done;
        do_reset();
        d_md_use = 1'b1; e_md_start = 1'b1; e_md_div = div;
        d_wr_addr = 5'd8; d_tnew = 2'd1;
        #1;
        chk({nm, "_start_stall"}, stall, 1);
        chk({nm, "_start_busy"}, md_busy, 0);
        @(posedge clk); #1;
        e_md_start = 1'b0;
        nb = 0; ns = 0; done = 1'b0;
        for (int i = 0; i < lat + 5 && !done; i++) begin
            #1;
            if (stall) begin
                ns++;
                if (md_busy) nb++;
                @(posedge clk); #1;
            end else begin
                done = 1'b1;
            end
        end
        chk({nm, "_exit"}, done, 1);
        chk({nm, "_busy_cycles"}, nb, lat);
        chk({nm, "_stall_cycles"}, ns, lat);
        chk({nm, "_busy_after"}, md_busy, 0);
        @(posedge clk); #1;
        set_nop();
    endtask

    // ---------------- table ----------------
    typedef struct {
        int rs, rt, tur, tut, wr, tn;
        int st, rsd, rtd, rse, rte, rtm;
    } vec_t;

    vec_t tbl [16];

    initial begin
        int st0, st1, rsd, rtd, rse, rte, rtm, ns;

        // lw $1 ; addu $2,$1,$3
        tbl[0]  = '{5, 0, 1, 3, 1, 2,   0, 0, 0, 0, 0, 0};
        tbl[1]  = '{1, 3, 1, 1, 2, 1,   1, 0, 0, 0, 0, 0};
        tbl[2]  = '{1, 3, 1, 1, 2, 1,   0, 0, 0, 0, 0, 0};
        tbl[3]  = '{0, 0, 3, 3, 0, 0,   0, 0, 0, 3, 0, 0};
        tbl[4]  = '{0, 0, 3, 3, 0, 0,   0, 0, 0, 0, 0, 0};
        // addu $1 ; beq $1,$2
        tbl[5]  = '{6, 7, 1, 1, 1, 1,   0, 0, 0, 0, 0, 0};
        tbl[6]  = '{1, 2, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0};
        tbl[7]  = '{1, 2, 0, 0, 0, 0,   0, 2, 0, 0, 0, 0};
        // jal ; jr $31 (beq's rs=$1 still forwards from W into E)
        tbl[8]  = '{0, 0, 3, 3, 31, 0,  0, 0, 0, 3, 0, 0};
        tbl[9]  = '{31, 0, 0, 3, 0, 0,  0, 1, 0, 0, 0, 0};
        // lw $0 ; addu $2,$0,$0 : $0 never hazards
        tbl[10] = '{5, 0, 1, 3, 0, 2,   0, 0, 0, 2, 0, 0};
        tbl[11] = '{0, 0, 1, 1, 2, 1,   0, 0, 0, 0, 0, 0};
        // lw $3 ; sw $3,0($4) : store data reaches M with W forward
        tbl[12] = '{4, 0, 1, 3, 3, 2,   0, 0, 0, 0, 0, 0};
        tbl[13] = '{4, 3, 1, 2, 0, 0,   0, 0, 0, 0, 0, 0};
        tbl[14] = '{0, 0, 3, 3, 0, 0,   0, 0, 0, 0, 0, 0};
        tbl[15] = '{0, 0, 3, 3, 0, 0,   0, 0, 0, 0, 0, 1};

        set_nop();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            set_d(tbl[i].rs, tbl[i].rt, tbl[i].tur, tbl[i].tut, tbl[i].wr, tbl[i].tn);
            #1;
            chk($sformatf("tbl%0d_stall", i), stall, tbl[i].st);
            chk($sformatf("tbl%0d_fwd_rs_d", i), fwd_rs_d, tbl[i].rsd);
            chk($sformatf("tbl%0d_fwd_rt_d", i), fwd_rt_d, tbl[i].rtd);
            chk($sformatf("tbl%0d_fwd_rs_e", i), fwd_rs_e, tbl[i].rse);
            chk($sformatf("tbl%0d_fwd_rt_e", i), fwd_rt_e, tbl[i].rte);
            chk($sformatf("tbl%0d_fwd_rt_m", i), fwd_rt_m, tbl[i].rtm);
            @(posedge clk); #1;
        end

        // div then mflo, mult then mfhi
        md_seq(1'b1, 10, "div");
        md_seq(1'b0, 5, "mult");

        // reset pulsed in the middle of a divide
        do_reset();
        d_md_use = 1'b1; e_md_start = 1'b1; e_md_div = 1'b1;
        @(posedge clk); #1;
        e_md_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
        end
        chk("rstmid_busy_before", md_busy, 1);
        chk("rstmid_stall_before", stall, 1);
        rst_n = 1'b0;
        #1;
        chk("rstmid_busy_async", md_busy, 0);
        chk("rstmid_stall_async", stall, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("rstmid_stall_release", stall, 0);
        @(posedge clk); #1;
        chk("rstmid_stall_after", stall, 0);
        chk("rstmid_busy_after", md_busy, 0);
        set_nop();

        // stall-only: addu $1 ; subu $4,$1,$1
        do_reset();
        set_d(6, 7, 1, 1, 1, 1);
        #1;
        chk("nf_addu_stall", nf_stall, 0);
        @(posedge clk); #1;
        set_d(1, 1, 1, 1, 4, 1);
        ns = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("nf_fwd_zero", {nf_fwd_rs_d, nf_fwd_rt_d, nf_fwd_rs_e, nf_fwd_rt_e,
                                nf_fwd_rt_m}, 0);
            if (!nf_stall) break;
            ns++;
            @(posedge clk); #1;
        end
        chk("nf_stall_cycles", ns, 3);
        @(posedge clk); #1;
        set_nop();

        // random stimulus against the model, both configurations
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            set_d($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
            d_md_use   = ($urandom_range(0, 7) == 0);
            e_md_start = !m_busy() && ($urandom_range(0, 11) == 0);
            e_md_div   = 1'($urandom_range(0, 1));
            #1;
            model_eval(0, st0, rsd, rtd, rse, rte, rtm);
            chk("rnd_stall", stall, st0);
            chk("rnd_fwd_rs_d", fwd_rs_d, rsd);
            chk("rnd_fwd_rt_d", fwd_rt_d, rtd);
            chk("rnd_fwd_rs_e", fwd_rs_e, rse);
            chk("rnd_fwd_rt_e", fwd_rt_e, rte);
            chk("rnd_fwd_rt_m", fwd_rt_m, rtm);
            chk("rnd_md_busy", md_busy, m_busy());
            model_eval(1, st1, rsd, rtd, rse, rte, rtm);
            chk("rnd_nf_stall", nf_stall, st1);
            chk("rnd_nf_fwd", {nf_fwd_rs_d, nf_fwd_rt_d, nf_fwd_rs_e, nf_fwd_rt_e,
                               nf_fwd_rt_m}, 0);
            chk("rnd_nf_md_busy", nf_md_busy, m_busy());
            model_advance(st0, st1);
            @(posedge clk); #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
